// File: rtl/seg7_display_sched.sv
// Rotating three-source 16-bit binary to 5-digit BCD display scheduler (double dabble).
// Optional build macro SEG7_BLANK_LEADING_EN blanks leading zero digits with 4'hF.
module seg7_display_sched #(
    parameter int unsigned DWELL_CYCLES = 100_000_000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [2:0]  src_valid,
    input  logic [47:0] src_value,
    input  logic        lock_en,
    input  logic [1:0]  lock_sel,
    output logic [31:0] disp_digits,
    output logic        disp_valid,
    output logic [1:0]  disp_src,
    output logic        busy
);

    localparam int unsigned CW = $clog2(DWELL_CYCLES + 1);
    localparam logic [CW-1:0] DWELL_RELOAD = CW'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t         state_q, state_d;
    logic [47:0]    shadow_q;
    logic [2:0]     seen_q, pend_q, clr_pend;
    logic [1:0]     cur_q, cur_d, sel, cand, rot_idx, lock_idx;
    logic           rot_ok;
    logic [CW-1:0]  dwell_q, dwell_d;
    logic [35:0]    work_q, work_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [31:0]    digits_q, digits_d;
    logic           dvalid_q, dvalid_d;
    logic [1:0]     dsrc_q, dsrc_d;

    function automatic logic [35:0] dabble_step(input logic [35:0] w);
        logic [19:0] bcd;
        bcd = w[35:16];
        for (int i = 0; i < 5; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        return {bcd[18:0], w[15:0], 1'b0};
    endfunction

    function automatic logic [31:0] format_digits(input logic [19:0] bcd);
        logic [31:0] r;
`ifdef SEG7_BLANK_LEADING_EN
        logic lead;
        r    = {12'hFFF, bcd};
        lead = 1'b1;
        // Digit 0 is never blanked so a zero value still shows "0".
        for (int i = 4; i >= 1; i--) begin
            if (lead && (bcd[4*i +: 4] == 4'd0)) r[4*i +: 4] = 4'hF;
            else lead = 1'b0;
        end
`else
        r = {12'h000, bcd};
`endif
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        dwell_d  = dwell_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        clr_pend = 3'b000;
        digits_d = digits_q;
        dvalid_d = 1'b0;
        dsrc_d   = dsrc_q;
        lock_idx = (lock_sel == 2'd3) ? 2'd0 : lock_sel;
        sel      = lock_en ? lock_idx : cur_q;
        cand     = cur_q;
        rot_ok   = 1'b0;
        rot_idx  = cur_q;
        // Walk offsets high to low so the nearest seen source in ascending order wins.
        for (int off = 2; off >= 1; off--) begin
            cand = 2'((32'(cur_q) + off) % 3);
            if (seen_q[cand]) begin
                rot_ok  = 1'b1;
                rot_idx = cand;
            end
        end

        case (state_q)
            IDLE: begin
                cur_d = sel;
                if (pend_q[sel]) begin
                    state_d = LOAD;
                    dwell_d = DWELL_RELOAD;
                end else if (dwell_q != '0) begin
                    dwell_d = dwell_q - CW'(1);
                end else if (!lock_en && rot_ok) begin
                    cur_d   = rot_idx;
                    state_d = LOAD;
                    dwell_d = DWELL_RELOAD;
                end else begin
                    dwell_d = DWELL_RELOAD;
                end
            end
            LOAD: begin
                work_d          = {20'd0, shadow_q[{cur_q, 4'b0000} +: 16]};
                clr_pend[cur_q] = 1'b1;
                cnt_d           = 4'd0;
                state_d         = SHIFT;
            end
            SHIFT: begin
                work_d = dabble_step(work_q);
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d  = DONE;
                    digits_d = format_digits(work_d[35:16]);
                    dvalid_d = 1'b1;
                    dsrc_d   = cur_q;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            seen_q   <= '0;
            pend_q   <= '0;
            cur_q    <= '0;
            dwell_q  <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            digits_q <= '0;
            dvalid_q <= 1'b0;
            dsrc_q   <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            dwell_q  <= dwell_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            dvalid_q <= dvalid_d;
            dsrc_q   <= dsrc_d;
            seen_q   <= seen_q | src_valid;
            // A fresh strobe outranks the clear issued in LOAD.
            pend_q   <= (pend_q & ~clr_pend) | src_valid;
            for (int k = 0; k < 3; k++) begin
                if (src_valid[k]) shadow_q[16*k +: 16] <= src_value[16*k +: 16];
            end
        end
    end

    assign disp_digits = digits_q;
    assign disp_valid  = dvalid_q;
    assign disp_src    = dsrc_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: doc/seg7_display_sched.md
SEG7_DISPLAY_SCHED -- requirements
Module: seg7_display_sched

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 100_000_000, giving display dwell per source in clk cycles (1 s at 100 MHz).
REQ-002 SHALL have port clk, input, 1, 100 MHz system clock.
REQ-003 SHALL have port resetn, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have port src_valid, input, 3, per-source one-cycle new-value strobe (bit k = source k).
REQ-005 SHALL have port src_value, input, 48, source k value on bits [16k+15:16k], unsigned binary.
REQ-006 SHALL have port lock_en, input, 1, suppress rotation and display lock_sel only.
REQ-007 SHALL have port lock_sel, input, 2, locked source index (value 3 treated as 0).
REQ-008 SHALL have port disp_digits, output, 32, eight BCD nibbles, nibble 0 = least significant digit.
REQ-009 SHALL have port disp_valid, output, 1, one-cycle strobe when disp_digits updates.
REQ-010 SHALL have port disp_src, output, 2, index of source shown in disp_digits.
REQ-011 SHALL have port busy, output, 1, high while conversion FSM is not IDLE.

Function
REQ-012 SHALL hold a 16-bit shadow register, seen flag and pending flag per source; src_valid[k] loads shadow k, sets seen k and pending k in the same edge.
REQ-013 SHALL use FSM states IDLE, LOAD, SHIFT, DONE; IDLE->LOAD on start, LOAD->SHIFT, SHIFT x16 iterations, then DONE->IDLE.
REQ-014 SHALL start a conversion from IDLE when current source has pending set, or when the dwell counter expires and rotation selects a different seen source.
REQ-015 SHALL in LOAD copy current shadow into a working register and clear current pending; a src_valid on that source in the same cycle sets pending again.
REQ-016 SHALL per SHIFT cycle add 3 to every BCD nibble >= 5, then shift {bcd,bin} left one bit (double dabble).
REQ-017 SHALL in DONE drive disp_digits = {12'h000, 20-bit BCD}, disp_src = current, disp_valid = 1; start-to-disp_valid latency = 18 cycles.
REQ-018 SHALL count dwell cycles in IDLE only; counter resets on every conversion start; expiry during conversion is deferred until IDLE.
REQ-019 SHALL rotate current to the next seen source in ascending order with wrap 2->0; unseen sources skipped; if no other source seen, expiry only reloads the counter.
REQ-020 SHALL, with lock_en=1, force current = lock_sel (remapped) on entry to IDLE, ignore dwell expiry, and convert when locked source pending.
REQ-021 SHALL never assert disp_valid while no source has been seen.
REQ-022 SHALL latch src_valid for non-current sources at any FSM state without disturbing the conversion.
REQ-023 SHALL produce 65535 as BCD 6,5,5,3,5 and 0 as all-zero nibbles.

Reset
REQ-024 SHALL on resetn=0 at a clk edge clear shadows, seen, pending, dwell counter, current=0, FSM=IDLE, disp_digits=0, disp_valid=0, disp_src=0, busy=0.
REQ-025 SHALL on reset mid-conversion abort without emitting disp_valid.

Configuration
REQ-026 SHALL with SEG7_BLANK_LEADING_EN defined replace leading zero nibbles 4..1 of disp_digits with 4'hF (nibble 0 always shown) and nibbles 5..7 with 4'hF.
REQ-027 SHALL without SEG7_BLANK_LEADING_EN output plain zero nibbles as in REQ-017.

Verification
REQ-028 Reset then src_valid[0] with value 1234 -> disp_valid 18 cycles later, disp_digits=32'h0000_1234, disp_src=0.
REQ-029 DWELL_CYCLES=50; sources 0 and 2 valid (100, 7) -> displays alternate 0,2,0 each ~50 IDLE cycles; source 1 never shown.
REQ-030 src_valid[0]=65535 during SHIFT of prior value 42 -> 42 displayed, then 65535 (32'h0006_5535) without waiting dwell.
REQ-031 lock_en=1, lock_sel=3, sources 0,1 seen -> only disp_src=0 shown; new source 1 values never displayed.
REQ-032 resetn low mid-SHIFT -> no disp_valid, all outputs zero next cycle.
REQ-033 SEG7_BLANK_LEADING_EN defined, value 0 -> disp_digits=32'hFFFF_FFF0; value 305 -> 32'hFFFF_F305.
